uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter on the data-memory side of the single-cycle core.
- Consumes the core's store port (MemWrite, DataAdr, WriteData) and returns ReadData for its address window.
- Buffers bytes in a FIFO and serialises them 8N1 (LSB first) on a tx line.
- Top-level read-data muxing against data RAM happens outside this block, using `hit`.

---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 54 +++++
 rtl/uart_tx_mmio.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: register offsets, STATUS bit positions and transmitter FSM encoding
// shared by the uart_tx_mmio slice.
package uart_tx_pkg;

    localparam logic [3:0] TXDATA_OFS  = 4'h0;
    localparam logic [3:0] STATUS_OFS  = 4'h4;
    localparam logic [3:0] BAUDDIV_OFS = 4'h8;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_BUSY   = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_PARITY = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with a power-of-two depth and a combinational
// read port; push when full and pop when empty are ignored.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter (TXDATA, STATUS, BAUDDIV) with a TX FIFO.
// Define UART_TX_PARITY_EN to append an even-parity bit to every frame (8E1).
module uart_tx_mmio
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        hit,
    output logic        tx
);

`ifdef UART_TX_PARITY_EN
    localparam logic      PARITY_PRESENT = 1'b1;
    localparam tx_state_t AFTER_DATA     = PARITY;
`else
    localparam logic      PARITY_PRESENT = 1'b0;
    localparam tx_state_t AFTER_DATA     = STOP;
`endif

    logic [3:0]  ofs;
    logic        wr_en;
    logic        txdata_wr;
    logic        fifo_push;
    logic        fifo_pop;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [15:0] baud_div_q;
    logic        ovf_q;
    logic [31:0] status_word;
    logic        unused_wdata;

    tx_state_t   state_q, state_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        tx_q, tx_d;
    logic        bit_end;
`ifdef UART_TX_PARITY_EN
    logic        par_q;
`endif

    assign hit          = (DataAdr[31:4] == BASE_ADDR[31:4]);
    assign ofs          = DataAdr[3:0];
    assign wr_en        = MemWrite && hit;
    assign txdata_wr    = wr_en && (ofs == TXDATA_OFS);
    assign fifo_push    = txdata_wr && !fifo_full;
    assign unused_wdata = ^WriteData[31:16];

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (WriteData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Reads are side-effect free: the core samples ReadData in the same cycle.
    always_comb begin
        status_word            = '0;
        status_word[ST_FULL]   = fifo_full;
        status_word[ST_EMPTY]  = fifo_empty;
        status_word[ST_BUSY]   = (state_q != IDLE);
        status_word[ST_OVF]    = ovf_q;
        status_word[ST_PARITY] = PARITY_PRESENT;
        ReadData               = '0;
        if (hit) begin
            case (ofs)
                STATUS_OFS:  ReadData = status_word;
                BAUDDIV_OFS: ReadData = {16'b0, baud_div_q};
                default:     ReadData = '0;
            endcase
        end
    end

    // A push into a full FIFO is dropped and flagged, even if a pop happens on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_div_q <= DEFAULT_DIV;
            ovf_q      <= 1'b0;
        end else begin
            if (wr_en && (ofs == BAUDDIV_OFS)) baud_div_q <= WriteData[15:0];
            if (txdata_wr && fifo_full) begin
                ovf_q <= 1'b1;
            end else if (wr_en && (ofs == STATUS_OFS) && WriteData[ST_OVF]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bit_end = (bit_cnt_q == div_q);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        fifo_pop  = 1'b0;
        tx_d      = 1'b1;

        if (state_q != IDLE) bit_cnt_d = bit_end ? '0 : bit_cnt_q + 16'd1;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_dout;
                    div_d     = baud_div_q;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = AFTER_DATA;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // tx is derived from the next state so the registered output lines up with state_q.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        div_q   <= div_d;
`ifdef UART_TX_PARITY_EN
        if (fifo_pop) par_q <= ^fifo_dout;
`endif
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed self-checking bench for uart_tx_mmio (register map,
// frame timing, FIFO overflow, baud change between frames, async reset).
module tb_uart_tx_mmio;

`ifdef UART_TX_PARITY_EN
    localparam int          NBITS = 11;
    localparam logic [31:0] PBIT  = 32'h10;
`else
    localparam int          NBITS = 10;
    localparam logic [31:0] PBIT  = 32'h0;
`endif
    localparam int          MAXN    = 160;
    localparam logic [31:0] A_TX    = 32'h0000_1000;
    localparam logic [31:0] A_ST    = 32'h0000_1004;
    localparam logic [31:0] A_BAUD  = 32'h0000_1008;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        hit;
    logic        tx;

    int n_tests = 0;
    int n_fail  = 0;

    logic rec_tx   [0:MAXN];
    logic rec_busy [0:MAXN];
    logic exp_tx   [0:MAXN];
    logic exp_busy [0:MAXN];

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .BASE_ADDR   (32'h0000_1000),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd433)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .hit       (hit),
        .tx        (tx)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        @(negedge clk);
        MemWrite  = 1'b0;
        WriteData = '0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        DataAdr = a;
        #1;
        d = ReadData;
    endtask

    task automatic clear_exp();
        for (int k = 0; k <= MAXN; k++) begin
            exp_tx[k]   = 1'b1;
            exp_busy[k] = 1'b0;
        end
    endtask

    // Expected line: start, 8 data bits LSB first, optional even parity, stop;
    // the FSM then spends one cycle in IDLE before the next frame.
    function automatic int add_frame(input int start, input logic [7:0] b, input int div);
        logic v;
        int   k;
        for (int i = 0; i < NBITS; i++) begin
            if (i == 0)                      v = 1'b0;
            else if (i <= 8)                 v = b[i-1];
            else if (i == 9 && NBITS == 11)  v = ^b;
            else                             v = 1'b1;
            for (int c = 0; c <= div; c++) begin
                k = start + i * (div + 1) + c;
                if (k <= MAXN) begin
                    exp_tx[k]   = v;
                    exp_busy[k] = 1'b1;
                end
            end
        end
        return start + NBITS * (div + 1) + 1;
    endfunction

    task automatic record(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            #1;
            rec_tx[k]   = tx;
            rec_busy[k] = ReadData[2];
        end
    endtask

    task automatic cmp_stream(input string tag, input int n, input bit with_busy);
        for (int k = 1; k <= n; k++) begin
            chk($sformatf("%s.tx[%0d]", tag, k), 32'(rec_tx[k]), 32'(exp_tx[k]));
            if (with_busy && k >= 2)
                chk($sformatf("%s.busy[%0d]", tag, k), 32'(rec_busy[k]), 32'(exp_busy[k]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          n;
        int          st;
        logic [7:0]  vec [9];
        vec = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'hA5, 8'h5A, 8'h0F, 8'hF0, 8'h96};

        // Reset values and register map
        repeat (3) @(negedge clk);
        chk("tx_in_reset", 32'(tx), 32'h1);
        bus_rd(A_ST, rd);    chk("status_in_reset", rd, 32'h2 | PBIT);
        @(negedge clk);
        rst_n = 1'b1;
        bus_rd(A_ST, rd);    chk("status_reset", rd, 32'h2 | PBIT);
        bus_rd(A_BAUD, rd);  chk("bauddiv_reset", rd, 32'd433);
        bus_rd(A_TX, rd);    chk("txdata_reads_0", rd, 32'h0);
        chk("hit_in_window", 32'(hit), 32'h1);
        bus_rd(32'h0000_100C, rd); chk("ofs_c_reads_0", rd, 32'h0);
        bus_rd(32'h0000_1006, rd); chk("unaligned_reads_0", rd, 32'h0);
        bus_rd(32'h0000_1010, rd); chk("outside_reads_0", rd, 32'h0);
        chk("hit_outside", 32'(hit), 32'h0);
        bus_rd(32'h0000_0FFC, rd);
        chk("hit_below", 32'(hit), 32'h0);

        // Writes outside the window or unaligned must not push
        bus_wr(32'h0000_1010, 32'h12);
        bus_wr(32'h0000_1001, 32'h34);
        bus_rd(A_ST, rd);    chk("no_push_on_miss", rd, 32'h2 | PBIT);
        chk("tx_idle", 32'(tx), 32'h1);

        // BAUDDIV upper bits ignored; single 0x55 frame at 4 cycles per bit
        bus_wr(A_BAUD, 32'hABCD_0003);
        bus_rd(A_BAUD, rd);  chk("bauddiv_wr", rd, 32'h3);
        clear_exp();
        st = add_frame(3, 8'h55, 3);
        n  = st + 4;
        fork
            record(n);
            begin
                bus_wr(A_TX, 32'h55);
                DataAdr = A_ST;
            end
        join
        cmp_stream("frame55", n, 1'b1);
        bus_rd(A_ST, rd);    chk("status_after_55", rd, 32'h2 | PBIT);

        // BAUDDIV=0, nine back-to-back pushes: FIFO fills exactly, no overflow
        bus_wr(A_BAUD, 32'h0);
        clear_exp();
        st = 3;
        for (int j = 0; j < 9; j++) st = add_frame(st, vec[j], 0);
        n = st + 4;
        fork
            record(n);
            begin
                for (int i = 0; i < 9; i++) begin
                    @(negedge clk);
                    MemWrite  = 1'b1;
                    DataAdr   = A_TX;
                    WriteData = {24'b0, vec[i]};
                end
                @(negedge clk);
                MemWrite = 1'b0;
                bus_rd(A_ST, rd); chk("status_9_pushed", rd, 32'h5 | PBIT);
            end
        join
        cmp_stream("b2b9", n, 1'b0);
        bus_rd(A_ST, rd);    chk("status_after_b2b", rd, 32'h2 | PBIT);

        // BAUDDIV changed mid-frame: only the following frame uses it
        bus_wr(A_BAUD, 32'h3);
        clear_exp();
        st = add_frame(3, 8'h07, 3);
        st = add_frame(st, 8'h3C, 7);
        n  = st + 2;
        fork
            record(n);
            begin
                bus_wr(A_TX, 32'h07);
                bus_wr(A_TX, 32'h3C);
                bus_wr(A_BAUD, 32'h7);
            end
        join
        cmp_stream("baudchg", n, 1'b0);
`ifdef UART_TX_PARITY_EN
        chk("parity_bit_07", 32'(rec_tx[3 + 9 * 4]), 32'h1);
`endif
        bus_rd(A_BAUD, rd);  chk("bauddiv_7", rd, 32'h7);

        // Ten back-to-back pushes at 4 cycles per bit: the tenth overflows
        bus_wr(A_BAUD, 32'h3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            MemWrite  = 1'b1;
            DataAdr   = A_TX;
            WriteData = 32'h0;
        end
        @(negedge clk);
        MemWrite = 1'b0;
        bus_rd(A_ST, rd);    chk("status_ovf", rd, 32'hD | PBIT);
        bus_wr(A_ST, 32'h8);
        bus_rd(A_ST, rd);    chk("status_ovf_clr", rd, 32'h5 | PBIT);
        chk("tx_low_mid_data", 32'(tx), 32'h0);

        // Asynchronous reset in the middle of a data bit
        rst_n = 1'b0;
        #1;
        chk("tx_reset_now", 32'(tx), 32'h1);
        bus_rd(A_ST, rd);    chk("status_during_rst", rd, 32'h2 | PBIT);
        bus_rd(A_BAUD, rd);  chk("bauddiv_during_rst", rd, 32'd433);
        @(negedge clk);
        rst_n = 1'b1;
        clear_exp();
        fork
            record(30);
            DataAdr = A_ST;
        join
        cmp_stream("post_rst", 30, 1'b1);
        bus_rd(A_ST, rd);    chk("status_post_rst", rd, 32'h2 | PBIT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
